// File: rtl/gsim_matrix_fetch.sv
// Matrix fetch engine: streams WORDS_PER_MAT-word matrices from memory into a small
// tagged row buffer feeding the GSIM core, one word per cycle when neither side stalls.
module gsim_matrix_fetch #(
  parameter int WORDS_PER_MAT = 17,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_en,
  input  logic [4:0]   i_matrix_num,
  output logic         o_done,
  output logic         o_mem_rreq,
  output logic [9:0]   o_mem_addr,
  input  logic         i_mem_rrdy,
  input  logic [255:0] i_mem_dout,
  input  logic         i_mem_dout_vld,
  output logic         o_row_vld,
  output logic [255:0] o_row_data,
  output logic [4:0]   o_row_mat,
  output logic         o_row_last,
  input  logic         i_row_rdy,
  output logic [1:0]   o_dbg_state
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WW = $clog2(WORDS_PER_MAT + 1);
  localparam logic [9:0]    WPM_W   = 10'(WORDS_PER_MAT);
  localparam logic [WW-1:0] WLAST   = WW'(WORDS_PER_MAT - 1);
  localparam logic [PW+1:0] DEPTH_W = (PW+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [9:0]    total_q, total_d;
  logic [9:0]    issue_cnt, recv_cnt;
  logic          inflight;
  logic [WW-1:0] recv_word;
  logic [4:0]    recv_mat;

  logic [255:0]  fifo_data [FIFO_DEPTH];
  logic [4:0]    fifo_mat  [FIFO_DEPTH];
  logic          fifo_last [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_cnt;
  logic [PW+1:0] occupancy;

  // Handshakes are strict valid/ready: a request is taken on a rising edge with
  // o_mem_rreq & i_mem_rrdy, a row is popped on a rising edge with o_row_vld & i_row_rdy,
  // and an offered request/row is held unchanged until taken.
  logic accept, push, pop, room, last_issue;

  assign total_d    = {5'b0, i_matrix_num} * WPM_W;
  assign accept     = o_mem_rreq & i_mem_rrdy;
  assign push       = i_mem_dout_vld & inflight;
  assign pop        = o_row_vld & i_row_rdy;
  // Counting the in-flight word reserves its slot, so the buffer can never overflow.
  assign occupancy  = {1'b0, fifo_cnt} + {{(PW+1){1'b0}}, inflight};
  assign room       = occupancy < DEPTH_W;
  assign last_issue = (issue_cnt == total_q - 10'd1);

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_en) state_d = (i_matrix_num == 5'd0) ? S_DONE : S_FETCH;
      S_FETCH: if (accept && last_issue) state_d = S_DRAIN;
      S_DRAIN: if (!inflight && (recv_cnt == total_q) && (fifo_cnt == '0)) state_d = S_DONE;
      S_DONE:  if (!i_en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_done      = (state_q == S_DONE);
    o_mem_rreq  = (state_q == S_FETCH) && (issue_cnt < total_q) && room;
    o_dbg_state = state_q;
  end

  assign o_mem_addr = issue_cnt;
  assign o_row_vld  = (fifo_cnt != '0);
  assign o_row_data = fifo_data[rd_ptr];
  assign o_row_mat  = fifo_mat[rd_ptr];
  assign o_row_last = fifo_last[rd_ptr];

  // Job counters; IDLE holds them cleared so every job starts at address 0.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      total_q   <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      recv_word <= '0;
      recv_mat  <= '0;
      inflight  <= 1'b0;
    end else begin
      if (state_q == S_IDLE) begin
        issue_cnt <= '0;
        recv_cnt  <= '0;
        recv_word <= '0;
        recv_mat  <= '0;
        if (i_en) total_q <= total_d;
      end else begin
        if (accept) issue_cnt <= issue_cnt + 10'd1;
        if (push) begin
          recv_cnt <= recv_cnt + 10'd1;
          if (recv_word == WLAST) begin
            recv_word <= '0;
            recv_mat  <= recv_mat + 5'd1;
          end else begin
            recv_word <= recv_word + WW'(1);
          end
        end
      end
      if (accept)    inflight <= 1'b1;
      else if (push) inflight <= 1'b0;
    end
  end

  // Row buffer
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_mat[i]  <= '0;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= i_mem_dout;
        fifo_mat[wr_ptr]  <= recv_mat;
        fifo_last[wr_ptr] <= (recv_word == WLAST);
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: doc/gsim_matrix_fetch.md
GSIM_MATRIX_FETCH -- requirements
Module: gsim_matrix_fetch

Interface
REQ-001 Parameter: WORDS_PER_MAT, default 17, meaning 256-bit words per matrix (16 A rows, then b).
REQ-002 Parameter: FIFO_DEPTH, default 4, meaning row-buffer entries (power of 2, >=2).
REQ-003 i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 i_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 i_en  in  1  level enable from system; rising level in IDLE starts a job.
REQ-006 i_matrix_num  in  5  matrices to fetch, sampled on job start.
REQ-007 o_done  out  1  job complete; held high until i_en low.
REQ-008 o_mem_rreq  out  1  read request to matrix memory.
REQ-009 o_mem_addr  out  10  word address of current request.
REQ-010 i_mem_rrdy  in  1  memory accepts request this cycle.
REQ-011 i_mem_dout  in  256  read data.
REQ-012 i_mem_dout_vld  in  1  i_mem_dout valid this cycle.
REQ-013 o_row_vld  out  1  buffer head valid toward GSIM core.
REQ-014 o_row_data  out  256  buffer head word.
REQ-015 o_row_mat  out  5  matrix index of head word.
REQ-016 o_row_last  out  1  head word is last word (b vector) of its matrix.
REQ-017 i_row_rdy  in  1  core pops head when o_row_vld & i_row_rdy.

Function
REQ-018 States: IDLE, FETCH, DRAIN, DONE.
REQ-019 IDLE -> FETCH when i_en=1 and latched i_matrix_num != 0; total = i_matrix_num*WORDS_PER_MAT (10-bit, max 31*17=527).
REQ-020 IDLE -> DONE directly when i_en=1 and i_matrix_num=0; no memory request issued.
REQ-021 Request accepted at edge where o_mem_rreq=1 and i_mem_rrdy=1; issue counter and o_mem_addr then increment by 1.
REQ-022 o_mem_addr = issue counter, starting at 0, addresses contiguous, no wrap within a job.
REQ-023 o_mem_rreq=1 only in FETCH, issue count < total, and fifo_count + inflight < FIFO_DEPTH.
REQ-024 o_mem_rreq and o_mem_addr held stable while i_mem_rrdy=0 (request retried, not dropped).
REQ-025 Memory latency fixed: data for request accepted at edge k arrives with i_mem_dout_vld=1 sampled at edge k+1; inflight is 0 or 1.
REQ-026 i_mem_dout_vld with inflight=0 ignored (no push).
REQ-027 Each returned word pushed to FIFO with tag matrix index and last flag; tags from a receive counter wrapping at WORDS_PER_MAT.
REQ-028 FIFO never overflows (guaranteed by REQ-023); simultaneous push and pop leaves count unchanged; pop on empty impossible (o_row_vld=0).
REQ-029 o_row_vld = FIFO not empty; o_row_data/mat/last stable while o_row_vld=1 and i_row_rdy=0.
REQ-030 FETCH -> DRAIN at edge where final request accepted.
REQ-031 DRAIN -> DONE when inflight=0, received = total and FIFO empty.
REQ-032 DONE: o_done=1; -> IDLE when i_en=0; o_done falls the cycle after.
REQ-033 i_en dropping in FETCH/DRAIN has no effect; job completes.
REQ-034 No new job starts until IDLE re-entered with i_en=0 then 1.
REQ-035 Throughput: with i_mem_rrdy=1 and i_row_rdy=1 continuously, one word per cycle.

Reset
REQ-036 i_reset_n=0 asynchronously forces IDLE, counters/FIFO cleared, inflight=0.
REQ-037 Reset values: o_done=0, o_mem_rreq=0, o_mem_addr=0, o_row_vld=0, o_row_data=0, o_row_mat=0, o_row_last=0.
REQ-038 Reset mid-job aborts it; data returning after release ignored per REQ-026.

Verification
REQ-039 matrix_num=1, rrdy=1, row_rdy=1 -> addrs 0..16, 17 pops, mat=0, last only on 17th, o_done after final pop.
REQ-040 matrix_num=31, rrdy random 50%, row_rdy random -> 527 words in address order, mat 0..30, last every 17th word, data matches memory.
REQ-041 matrix_num=2, row_rdy=0 for 20 cycles -> exactly 4 requests issued then rreq=0 until pops resume; no loss.
REQ-042 matrix_num=0 -> o_done=1 next cycle, zero requests; i_en=0 -> o_done=0.
REQ-043 i_reset_n low at word 9 of matrix_num=3 -> all outputs at reset values immediately; new job restarts at addr 0.
REQ-044 Spurious i_mem_dout_vld in IDLE -> o_row_vld stays 0.
